instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction FIFO: fetches a programmed run of 32-bit instruction words from instruction memory and pushes them into instruction_fifo.
- Performs address generation, the memory request/grant handshake, outstanding-request tracking and credit-based flow control, so a FIFO push can never overflow.
- Sits between instruction memory and instruction_fifo, in front of the warp scheduler.

Parameters:
- FIFO_DEPTH, 16, depth of the downstream instruction_fifo; initial credit count.
- MAX_OUTSTANDING, 4, maximum granted-but-unreturned memory requests.
- ADDR_W, 32, instruction address width (byte address, word aligned).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches start_pc and num_instr; ignored unless IDLE.
- start_pc  input  ADDR_W  first fetch address; bits [1:0] ignored, treated as 0.
- num_instr  input  16  words to fetch; 0 means immediate done.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse when the run completes.
- imem_req  output  1  memory request valid.
- imem_addr  output  ADDR_W  request address.
- imem_gnt  input  1  request accepted this cycle, when imem_req=1.
- imem_rvalid  input  1  read data valid; in order, at least 1 cycle after grant.
- imem_rdata  input  32  read data.
- fifo_push  output  1  to instruction_fifo push.
- fifo_data  output  32  to instruction_fifo data_in.
- fifo_pop_ack  input  1  accepted FIFO pop (pop && !empty); returns one credit.

Behaviour:
- Reset values: busy=0, done=0, imem_req=0, imem_addr=0, fifo_push=0, fifo_data=0. Internal state: credits=FIFO_DEPTH, outstanding=0, req_left=0, rsp_left=0, state=IDLE.
- States:
  - IDLE: on start with num_instr>0, go to FETCH; pc={start_pc[ADDR_W-1:2],2'b00}, req_left=rsp_left=num_instr.
  - IDLE: on start with num_instr=0, pulse done next cycle and stay IDLE.
  - FETCH: go to DRAIN when the last request is granted (req_left reaches 0).
  - DRAIN: go to IDLE when rsp_left reaches 0; done pulses the cycle the last fifo_push is high.
- imem_req = (state==FETCH) && credits>0 && outstanding<MAX_OUTSTANDING && req_left>0.
  - Combinational from registered state; imem_addr=pc.
  - Once req=1 it holds with a stable addr until gnt (no retraction).
- Request granted (req&&gnt): pc += 4 (wraps modulo 2^ADDR_W), req_left--, outstanding++, credits--.
- Response (rvalid):
  - Registered next cycle: fifo_push=1, fifo_data=imem_rdata.
  - outstanding--, rsp_left--.
  - A response with outstanding==0 is a protocol error: ignored, no push.
- Credits:
  - Net update per cycle = +fifo_pop_ack − grant. Both in one cycle leaves credits unchanged.
  - Credits never exceed FIFO_DEPTH; a pop_ack at FIFO_DEPTH is ignored.
  - Credits persist across runs.
- Outstanding:
  - Net update = +grant − rvalid; both in one cycle leaves it unchanged.
  - Grant and rvalid may coincide.
- start while busy is ignored.
- Throughput: 1 word/cycle with single-cycle gnt, ≥MAX_OUTSTANDING-deep memory pipelining and continuous pops.
- Asynchronous reset mid-run:
  - All state returns to reset values immediately.
  - In-flight memory responses arriving after reset are dropped, since outstanding==0.
  - The FIFO must be reset together with this block.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds output stall_cycles (32 bits, reset 0). It increments each FETCH cycle with req_left>0 and credits==0, and saturates at 2^32−1. Cleared on start.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, then start_pc=0x100, num_instr=4, gnt=1 always, rvalid 2 cycles after grant, rdata=addr^0xA5A50000 -> requests at 0x100,0x104,0x108,0x10C; pushes data 0xA5A50100..0xA5A5010C in order; done pulses with the 4th push; busy=0 the next cycle.
- num_instr=20, FIFO_DEPTH=16, no pops -> exactly 16 grants, then imem_req=0 (credits=0). 4 fifo_pop_ack pulses -> 4 more grants; done after push 20. With FETCH_STATS_EN, stall_cycles>0.
- gnt held low 5 cycles on the first request -> req stays high and addr stays stable; 1 grant only.
- Memory latency 10 cycles, MAX_OUTSTANDING=4, num_instr=8 -> never more than 4 grants ahead of responses; all 8 pushed in order.
- Grant, rvalid and pop_ack in the same cycle -> credits and outstanding net unchanged; no lost or extra push.
- Assert rst_n=0 mid-run with 2 outstanding -> outputs at reset values; late rvalid produces no push. start_pc=0x7, num_instr=0 -> done pulse, no request.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: producer side of the instruction FIFO.
// Generates word addresses for a programmed run, performs the memory
// request/grant handshake, tracks outstanding reads and FIFO credits, and
// pushes returned words into the instruction FIFO one cycle after rvalid.
// Optional build macro: FETCH_STATS_EN adds the stall_cycles counter output.
module instr_fetch_unit #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [15:0]       num_instr,
  output logic              busy,
  output logic              done,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              fifo_push,
  output logic [31:0]       fifo_data,
  input  logic              fifo_pop_ack
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         req_left_q, req_left_d;
  logic [15:0]         rsp_left_q, rsp_left_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic                push_q, push_d;
  logic [31:0]         data_q, data_d;
  logic                done_q, done_d;

  logic grant;
  logic rsp_ok;
  logic pop_ok;

  // Request is a pure function of registered state, so once raised it can
  // only drop through a grant (credits/outstanding only move against it then).
  always_comb begin
    imem_req = (state_q == S_FETCH) && (credits_q != '0) &&
               (outstanding_q < OUT_MAX) && (req_left_q != '0);
    grant    = imem_req && imem_gnt;
    // A response with nothing outstanding (e.g. in flight across a reset) is dropped.
    rsp_ok   = imem_rvalid && (outstanding_q != '0);
    // Credits are capped at the FIFO depth; a stray pop_ack there is ignored.
    pop_ok   = fifo_pop_ack && (credits_q != CRED_MAX);
  end

  // Next-state logic: run FSM, address/count bookkeeping, credits and push.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_left_d    = req_left_q;
    rsp_left_d    = rsp_left_q;
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    push_d        = rsp_ok;
    data_d        = rsp_ok ? imem_rdata : data_q;
    done_d        = 1'b0;

    if (grant) begin
      pc_d       = pc_q + ADDR_W'(4);
      req_left_d = req_left_q - 16'd1;
    end

    if (rsp_ok && (rsp_left_q != '0)) begin
      rsp_left_d = rsp_left_q - 16'd1;
      // done lines up with the push of the final word
      if (rsp_left_q == 16'd1) begin
        done_d = 1'b1;
      end
    end

    case ({pop_ok, grant})
      2'b10:   credits_d = credits_q + CRED_W'(1);
      2'b01:   credits_d = credits_q - CRED_W'(1);
      default: credits_d = credits_q;
    endcase

    case ({grant, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_instr != '0) begin
            state_d    = S_FETCH;
            pc_d       = start_pc & ~(ADDR_W'(3));
            req_left_d = num_instr;
            rsp_left_d = num_instr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (grant && (req_left_q == 16'd1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // rsp_left hit zero on the final response; leave after the done cycle
        if (rsp_left_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      req_left_q    <= '0;
      rsp_left_q    <= '0;
      credits_q     <= CRED_MAX;
      outstanding_q <= '0;
      push_q        <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_left_q    <= req_left_d;
      rsp_left_q    <= rsp_left_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      push_q        <= push_d;
      data_q        <= data_d;
      done_q        <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign imem_addr = pc_q;
  assign fifo_push = push_q;
  assign fifo_data = data_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Count FETCH cycles blocked purely by lack of FIFO credit; saturating.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == S_FETCH) && (req_left_q != '0) &&
                 (credits_q == '0) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized memory/FIFO environment with a
// transaction-level reference model (expected word list, credit and
// outstanding counters) checked every cycle.
module tb_instr_fetch_unit;

  localparam int FIFO_DEPTH = 16;
  localparam int MAX_OUT    = 4;
  localparam int ADDR_W     = 32;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_pc;
  logic [15:0] num_instr;
  logic        busy;
  logic        done;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fifo_push;
  logic [31:0] fifo_data;
  logic        fifo_pop_ack;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  instr_fetch_unit #(
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .num_instr(num_instr), .busy(busy), .done(done), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .fifo_pop_ack(fifo_pop_ack)
`ifdef FETCH_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int          m_credits, m_out, m_req_left, m_rsp_left, m_occ, m_granted;
  bit          m_busy, push_exp, done_exp;
  logic [31:0] m_base;
  logic [31:0] exp_q[$];
  int          mem_due[$];
  logic [31:0] mem_data[$];
  int          last_due;
  int          grants_total;

  // environment knobs
  int lat_min, lat_max, gnt_pct, gnt_block, pop_pct, pop_budget, spur_pct;
  bit force_pop;
  bit          st_req;
  logic [31:0] st_pc;
  logic [15:0] st_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_credits = FIFO_DEPTH; m_out = 0; m_req_left = 0; m_rsp_left = 0;
    m_occ = 0; m_granted = 0; m_busy = 0; push_exp = 0; done_exp = 0;
    m_base = 0; exp_q.delete();
  endtask

  // One clock cycle: observe outputs, drive inputs, advance model, step clock.
  task automatic cycle();
    bit req_exp, g, rv, pp, rsp_cnt, pushed, busy_nx, done_nx;
    logic [31:0] a_exp;
    int lat, due;
    pushed = push_exp;
    check("push", fifo_push, push_exp);
    if (push_exp && exp_q.size() > 0) check("data", fifo_data, exp_q.pop_front());
    check("done", done, done_exp);
    check("busy", busy, m_busy);
    req_exp = m_busy && (m_req_left > 0) && (m_credits > 0) && (m_out < MAX_OUT);
    a_exp   = m_base + 32'(4 * m_granted);
    check("req", imem_req, req_exp);
    if (req_exp) check("addr", imem_addr, a_exp);

    g = ($urandom_range(99) < gnt_pct);
    if (req_exp && gnt_block > 0) begin g = 0; gnt_block--; end
    rv = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    pp = force_pop || ((pop_budget != 0) && (m_occ > 0) && ($urandom_range(99) < pop_pct));
    if (pp && !force_pop && pop_budget > 0) pop_budget--;
    if (m_busy && !st_req && $urandom_range(99) < spur_pct) begin
      st_req = 1; st_pc = $urandom; st_n = 16'($urandom_range(1, 9));
    end

    imem_gnt     = g;
    imem_rvalid  = rv;
    imem_rdata   = rv ? mem_data[0] : $urandom;
    fifo_pop_ack = pp;
    start        = st_req;
    start_pc     = st_pc;
    num_instr    = st_n;
    if (rv) begin void'(mem_due.pop_front()); void'(mem_data.pop_front()); end

    busy_nx = m_busy;
    done_nx = 0;
    if (done_exp && m_busy) busy_nx = 0;
    rsp_cnt = rv && (m_out > 0);
    if (pp && m_credits < FIFO_DEPTH) m_credits++;
    if (pp && m_occ > 0) m_occ--;
    if (rsp_cnt) begin
      m_out--; m_rsp_left--;
      if (m_rsp_left == 0) done_nx = 1;
    end
    if (req_exp && g) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_due.push_back(due);
      mem_data.push_back(a_exp ^ KEY);
      m_granted++; m_req_left--; m_out++; m_credits--; grants_total++;
    end
    if (st_req && !m_busy) begin
      if (st_n != 0) begin
        busy_nx = 1; m_base = st_pc & ~32'd3; m_granted = 0;
        m_req_left = st_n; m_rsp_left = st_n;
        for (int i = 0; i < int'(st_n); i++) exp_q.push_back((m_base + 32'(4 * i)) ^ KEY);
      end else begin
        done_nx = 1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    if (pushed) m_occ++;
    push_exp = rsp_cnt;
    done_exp = done_nx;
    m_busy   = busy_nx;
    st_req   = 0;
    start    = 0;
  endtask

  task automatic launch(input logic [31:0] pc, input logic [15:0] n);
    st_req = 1; st_pc = pc; st_n = n;
    cycle();
  endtask

  task automatic run(input string tag, input int maxc);
    int k = 0;
    while ((m_busy || push_exp || done_exp) && k < maxc) begin cycle(); k++; end
    check({tag, "_bound"}, 32'(k < maxc), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    pop_budget = -1; pop_pct = 100;
    while (m_occ > 0 && k < 100) begin cycle(); k++; end
    check("drain_bound", 32'(k < 100), 32'd1);
  endtask

  initial begin
    int g0, k;
    rst_n = 0; start = 0; start_pc = 0; num_instr = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; fifo_pop_ack = 0;
    st_req = 0; st_pc = 0; st_n = 0; force_pop = 0; spur_pct = 0;
    lat_min = 2; lat_max = 2; gnt_pct = 100; gnt_block = 0; pop_pct = 100; pop_budget = -1;
    last_due = 0; grants_total = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_req", imem_req, 0); check("rst_addr", imem_addr, 0);
    check("rst_push", fifo_push, 0); check("rst_data", fifo_data, 0);
`ifdef FETCH_STATS_EN
    check("rst_stall", stall_cycles, 0);
`endif
    rst_n = 1;
    @(posedge clk); #1;

    // basic 4-word run, gnt always, latency 2
    g0 = grants_total;
    launch(32'h100, 16'd4);
    run("basic", 100);
    check("basic_grants", 32'(grants_total - g0), 32'd4);

    // credit limit: pops at full credit ignored, 20 words with no pops
    drain();
    force_pop = 1; cycle(); cycle(); force_pop = 0;
    pop_budget = 0; lat_min = 1; lat_max = 3;
    g0 = grants_total;
    launch(32'h2000, 16'd20);
    repeat (40) cycle();
    check("credit_grants16", 32'(grants_total - g0), 32'd16);
    check("credit_req_low", imem_req, 0);
`ifdef FETCH_STATS_EN
    check("stall_nz", 32'(stall_cycles != 0), 32'd1);
`endif
    pop_budget = 4; pop_pct = 100;
    repeat (10) cycle();
    pop_budget = 0;
    run("credit", 200);
    check("credit_grants20", 32'(grants_total - g0), 32'd20);

    // grant withheld 5 cycles on the first request
    drain();
    gnt_block = 5;
    g0 = grants_total;
    launch(32'h300, 16'd1);
    run("gnt_hold", 100);
    check("gnt_hold_grants", 32'(grants_total - g0), 32'd1);

    // long memory latency bounds outstanding
    lat_min = 10; lat_max = 10; pop_budget = -1; pop_pct = 50;
    g0 = grants_total;
    launch(32'h4000, 16'd8);
    run("lat10", 300);
    check("lat10_grants", 32'(grants_total - g0), 32'd8);

    // address wrap
    lat_min = 1; lat_max = 4;
    launch(32'hFFFF_FFF9, 16'd4);
    run("wrap", 200);

    // randomized runs with coincident grant/rvalid/pop and ignored starts
    for (int r = 0; r < 12; r++) begin
      lat_min = $urandom_range(1, 3); lat_max = lat_min + $urandom_range(0, 5);
      gnt_pct = $urandom_range(40, 100); pop_pct = $urandom_range(20, 100);
      pop_budget = -1; spur_pct = 5;
      launch($urandom, 16'($urandom_range(1, 24)));
      spur_pct = 5;
      run("rand", 2000);
      spur_pct = 0;
    end

    // asynchronous reset with two reads in flight
    drain();
    lat_min = 8; lat_max = 8; gnt_pct = 100; pop_budget = 0;
    launch(32'h500, 16'd8);
    k = 0;
    while (m_out < 2 && k < 20) begin cycle(); k++; end
    check("rst_mid_bound", 32'(k < 20), 32'd1);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0); check("arst_done", done, 0);
    check("arst_req", imem_req, 0); check("arst_addr", imem_addr, 0);
    check("arst_push", fifo_push, 0); check("arst_data", fifo_data, 0);
    model_reset();
    #3 rst_n = 1;
    @(posedge clk); #1; cyc++;
    repeat (14) cycle();
    check("late_rsp_drained", 32'(mem_due.size()), 32'd0);

    // zero-length run from unaligned pc
    launch(32'h7, 16'd0);
    check("zero_done", done, 1);
    check("zero_req", imem_req, 0);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
